// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed hex display scanner with frame-synchronous data updates.
// Define DISP_SCAN_LZ_BLANK_EN to enable leading-zero blanking.
module disp_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  blank,
  output logic                  frame_done
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt;
  logic [1:0] idx, nidx;
  logic [4*DIGITS-1:0] disp, pend, nd;
  logic pv, tick, wrap, lz;
  logic [3:0] nb;
  logic [DIGITS-1:0] nsel;
  always_comb begin
    tick = cnt == CW'(PRESCALE - 1);
    nidx = idx + 2'd1;
    wrap = tick && idx == 2'(DIGITS - 1);
    // a load landing on the boundary tick bypasses the pending register
    nd = wrap ? (load ? data_in : (pv ? pend : disp)) : disp;
    nb = nd[{nidx, 2'b00} +: 4];
`ifdef DISP_SCAN_LZ_BLANK_EN
    lz = nidx != 2'd0 && (nd >> {nidx, 2'b00}) == '0;
`else
    lz = 1'b0;
`endif
    nsel = lz ? '0 : DIGITS'(1) << nidx;
  end
`ifndef DISP_SCAN_LZ_BLANK_EN
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      disp <= '0;
      pend <= '0;
      pv <= 1'b0;
      bcd_out <= '0;
      dig_sel <= DIGITS'(1);
      frame_done <= 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
      blank <= 1'b0;
`endif
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (wrap) begin
        disp <= nd;
        pv <= 1'b0;
      end else if (load) begin
        pend <= data_in;
        pv <= 1'b1;
      end
      if (tick) begin
        idx <= nidx;
        bcd_out <= nb;
        dig_sel <= nsel;
`ifdef DISP_SCAN_LZ_BLANK_EN
        blank <= lz;
`endif
      end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed checks of scan order, frame-synchronous loads, reset and blanking.
module tb_disp_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] bcd_out, dig_sel;
  logic blank, frame_done;
  int total = 0, bad = 0;
  disp_scan_ctrl #(.PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .bcd_out(bcd_out), .dig_sel(dig_sel), .blank(blank), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one 4-cycle dwell on digit di of display value dv; optional load at sample li
  task automatic dwell(input int di, input logic [15:0] dv, input bit fd, input int li, input logic [15:0] lv);
    logic [3:0] es = 4'b0001 << di;
    logic eb = 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
    if (di != 0 && (dv >> (4 * di)) == 16'h0) begin
      es = 4'b0000;
      eb = 1'b1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sel d%0d s%0d", di, i), 16'(dig_sel), 16'(es));
      chk($sformatf("bcd d%0d s%0d", di, i), 16'(bcd_out), 16'(dv[4*di +: 4]));
      chk($sformatf("blank d%0d s%0d", di, i), 16'(blank), 16'(eb));
      chk($sformatf("fd d%0d s%0d", di, i), 16'(frame_done), 16'(fd && i == 0));
      if (i == li) begin
        load = 1'b1;
        data_in = lv;
      end
      @(negedge clk);
      load = 1'b0;
    end
  endtask
  task automatic frame(input logic [15:0] dv, input bit fd);
    for (int d = 0; d < 4; d++) dwell(d, dv, fd && d == 0, -1, 16'h0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst bcd", 16'(bcd_out), 16'h0);
    chk("rst sel", 16'(dig_sel), 16'h1);
    chk("rst blank", 16'(blank), 16'h0);
    chk("rst fd", 16'(frame_done), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h0000, 1'b0);
    dwell(0, 16'h0000, 1'b1, -1, 16'h0);
    dwell(1, 16'h0000, 1'b0, 2, 16'hA5C3);
    dwell(2, 16'h0000, 1'b0, -1, 16'h0);
    dwell(3, 16'h0000, 1'b0, -1, 16'h0);
    dwell(0, 16'hA5C3, 1'b1, 1, 16'h1111);
    dwell(1, 16'hA5C3, 1'b0, -1, 16'h0);
    dwell(2, 16'hA5C3, 1'b0, 0, 16'h2222);
    dwell(3, 16'hA5C3, 1'b0, -1, 16'h0);
    dwell(0, 16'h2222, 1'b1, -1, 16'h0);
    dwell(1, 16'h2222, 1'b0, -1, 16'h0);
    dwell(2, 16'h2222, 1'b0, -1, 16'h0);
    dwell(3, 16'h2222, 1'b0, 3, 16'h00F0);
    frame(16'h00F0, 1'b1);
    dwell(0, 16'h00F0, 1'b1, 1, 16'h9999);
    dwell(1, 16'h00F0, 1'b0, -1, 16'h0);
    chk("pre-rst sel", 16'(dig_sel), 16'(4'b0100) & {12'h0, 4'(~blank ? 4'b0100 : 4'b0000)});
    chk("pre-rst bcd", 16'(bcd_out), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async bcd", 16'(bcd_out), 16'h0);
    chk("async sel", 16'(dig_sel), 16'h1);
    chk("async blank", 16'(blank), 16'h0);
    chk("async fd", 16'(frame_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h0000, 1'b0);
    frame(16'h0000, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
